// File: rtl/timer_counter.sv
// timer_counter: programmable prescaled up/down timer with periodic/one-shot modes,
// synchronous load, terminal-count pulse and sticky event flag. (evt is the terminal-count pulse.)
module timer_counter #(
    parameter int WIDTH          = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      direction,
    input  logic                      one_shot,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          top,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      clear_event,
    output logic [WIDTH-1:0]          value,
    output logic                      tick,
    output logic                      evt,
    output logic                      event_sticky,
    output logic                      done
);
    logic [PRESCALE_WIDTH-1:0] pcount;
    logic                      running, step, terminal;
    logic [WIDTH-1:0]          next_value;

    always_comb begin
        running    = enable && !done;
        step       = running && (pcount >= prescale);
        terminal   = direction ? (value >= top) : (value == '0);
        next_value = terminal ? (one_shot ? value : (direction ? '0 : top))
                              : (direction ? value + 1'b1 : value - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value        <= '0;
            pcount       <= '0;
            tick         <= 1'b0;
            evt          <= 1'b0;
            event_sticky <= 1'b0;
            done         <= 1'b0;
        end else if (load) begin
            value        <= load_value;
            pcount       <= '0;
            tick         <= 1'b0;
            evt          <= 1'b0;
            event_sticky <= event_sticky && !clear_event;
            done         <= 1'b0;
        end else begin
            tick         <= step;
            evt          <= step && terminal;
            event_sticky <= (step && terminal) || (event_sticky && !clear_event);
            if (running) pcount <= step ? '0 : pcount + 1'b1;
            if (step) begin
                value <= next_value;
                done  <= done || (terminal && one_shot);
            end
        end
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed scenarios plus randomized stimulus, every cycle checked
// against a behavioural model of the timer.
module tb_timer_counter;
    localparam int W  = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1, enable = 1'b0, direction = 1'b1, one_shot = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [W-1:0]  top = '0, load_value = '0;
    logic          load = 1'b0, clear_event = 1'b0;
    logic [W-1:0]  value;
    logic          tick, evt, event_sticky, done;

    int vectors = 0, miscompares = 0;
    int m_value, m_pc, m_tick, m_evt, m_sticky, m_done;
    bit model_valid = 0;

    timer_counter #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .direction(direction), .one_shot(one_shot),
        .prescale(prescale), .top(top), .load(load), .load_value(load_value),
        .clear_event(clear_event), .value(value), .tick(tick), .evt(evt),
        .event_sticky(event_sticky), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: the timer's rules in plain integer arithmetic.
    always @(posedge clk) begin
        if (rst) begin
            m_value = 0; m_pc = 0; m_tick = 0; m_evt = 0; m_sticky = 0; m_done = 0;
            model_valid = 1;
        end else if (load) begin
            m_value = int'(load_value); m_pc = 0; m_tick = 0; m_evt = 0; m_done = 0;
            if (clear_event) m_sticky = 0;
        end else begin
            m_tick = 0; m_evt = 0;
            if (enable && m_done == 0) begin
                if (m_pc >= int'(prescale)) begin
                    m_pc = 0;
                    m_tick = 1;
                    m_evt = direction ? int'(m_value >= int'(top)) : int'(m_value == 0);
                    if (m_evt == 0)
                        m_value = (m_value + (direction ? 1 : -1) + (1 << W)) % (1 << W);
                    else if (one_shot)
                        m_done = 1;
                    else
                        m_value = direction ? 0 : int'(top);
                end else m_pc = m_pc + 1;
            end
            if (m_evt == 1) m_sticky = 1;
            else if (clear_event) m_sticky = 0;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("value", int'(value), m_value);
            check("tick", int'(tick), m_tick);
            check("evt", int'(evt), m_evt);
            check("event_sticky", int'(event_sticky), m_sticky);
            check("done", int'(done), m_done);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_value = W'(v);
        edges(1);
        load = 1'b0;
    endtask

    initial begin
        edges(2);
        rst = 1'b0;
        check("reset_value", int'(value), 0);
        check("reset_done", int'(done), 0);
        // up periodic, top=3
        top = 3; enable = 1'b1;
        edges(3);
        check("up_value3", int'(value), 3);
        edges(1);
        check("up_wrap_value", int'(value), 0);
        check("up_wrap_evt", int'(evt), 1);
        // prescale with freeze
        top = 2; prescale = 2;
        do_load(0);
        edges(3);
        check("ps_value", int'(value), 1);
        check("ps_tick", int'(tick), 1);
        edges(1);
        enable = 1'b0;
        edges(5);
        check("freeze_value", int'(value), 1);
        check("freeze_tick", int'(tick), 0);
        enable = 1'b1;
        edges(1);
        check("resume_notick", int'(tick), 0);
        edges(1);
        check("resume_value", int'(value), 2);
        // down one-shot
        prescale = 0; direction = 1'b0; one_shot = 1'b1;
        do_load(5);
        check("load_value5", int'(value), 5);
        check("load_tick", int'(tick), 0);
        edges(5);
        check("down_value0", int'(value), 0);
        check("down_noevt", int'(evt), 0);
        edges(1);
        check("oneshot_evt", int'(evt), 1);
        check("oneshot_done", int'(done), 1);
        edges(1);
        check("oneshot_hold", int'(value), 0);
        check("oneshot_evt_once", int'(evt), 0);
        do_load(3);
        check("reload_done", int'(done), 0);
        edges(1);
        check("reload_count", int'(value), 2);
        // sticky with clear held high
        direction = 1'b1; one_shot = 1'b0; top = 3; clear_event = 1'b1;
        do_load(0);
        edges(4);
        check("sticky_set_wins", int'(event_sticky), 1);
        edges(1);
        check("sticky_cleared", int'(event_sticky), 0);
        clear_event = 1'b0;
        // load during step cycle
        do_load(7);
        check("load_prio_value", int'(value), 7);
        check("load_prio_evt", int'(evt), 0);
        // boundary wrap at 15 and lowering top
        top = 15;
        do_load(14);
        edges(2);
        check("wrap15_value", int'(value), 0);
        check("wrap15_evt", int'(evt), 1);
        do_load(9);
        top = 2;
        edges(1);
        check("lower_top_value", int'(value), 0);
        check("lower_top_evt", int'(evt), 1);
        // reset mid-operation with done and sticky set
        top = 0; one_shot = 1'b1;
        do_load(0);
        edges(1);
        check("pre_rst_done", int'(done), 1);
        check("pre_rst_sticky", int'(event_sticky), 1);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        check("rst_done", int'(done), 0);
        check("rst_sticky", int'(event_sticky), 0);
        check("rst_value", int'(value), 0);
        // randomized
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            enable      = ($urandom_range(0, 9) != 0);
            direction   = ($urandom_range(0, 63) == 0) ? ~direction : direction;
            one_shot    = ($urandom_range(0, 63) == 0) ? ~one_shot : one_shot;
            prescale    = ($urandom_range(0, 31) == 0) ? PW'($urandom_range(0, 3)) : prescale;
            top         = ($urandom_range(0, 31) == 0) ? W'($urandom) : top;
            load        = ($urandom_range(0, 24) == 0);
            load_value  = W'($urandom);
            clear_event = ($urandom_range(0, 7) == 0);
            edges(1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Parametrised successor to the basic free-running counter, providing a general-purpose timer for peripheral blocks.
- Adds a runtime-programmable prescaler, programmable terminal value (top), runtime up/down direction, periodic or one-shot mode, and synchronous load.
- Adds a terminal-count event pulse and a sticky event flag for interrupt generation.
- Sits behind a peripheral register interface; all control inputs are driven from registers.

Parameters:
WIDTH, 16, width of count value, top and load_value
PRESCALE_WIDTH, 8, width of prescaler compare value

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  1 = timer may count; 0 = freeze prescaler and value
direction  input  1  1 = count up, 0 = count down
one_shot  input  1  1 = stop at terminal count, 0 = periodic reload
prescale  input  PRESCALE_WIDTH  step every prescale+1 enabled cycles
top  input  WIDTH  terminal value (up) / reload value (down)
load  input  1  synchronous load strobe
load_value  input  WIDTH  value loaded on load
clear_event  input  1  clears event_sticky
value  output  WIDTH  current count (registered)
tick  output  1  one-cycle pulse on each counter step (registered)
event  output  1  one-cycle pulse on terminal count (registered)
event_sticky  output  1  latched event flag
done  output  1  one-shot has reached terminal; counting halted

Behaviour:
- Single clock domain; all state updates on posedge clk. Reset is synchronous, active-high.
- Reset values: value=0, internal prescaler count=0, tick=0, event=0, event_sticky=0, done=0.
- running = enable && !done.
  - While !running: prescaler and value hold; tick and event are 0.
- Prescaler:
  - While running, on each edge: if pcount >= prescale then pcount<=0 and a step occurs; else pcount<=pcount+1.
  - prescale=0 gives a step every running cycle.
  - If prescale is lowered below pcount, the step occurs on the next running edge (>= compare).
- Step, up mode (direction=1):
  - If value >= top (terminal): event<=1.
    - Periodic: value<=0.
    - One-shot: value holds, done<=1.
  - Else value<=value+1.
- Step, down mode (direction=0):
  - If value == 0 (terminal): event<=1.
    - Periodic: value<=top.
    - One-shot: value holds at 0, done<=1.
  - Else value<=value-1.
- tick<=1 on the edge where a step occurs, else 0. event<=1 only on a terminal step, else 0.
  - Both are high for exactly one cycle per step and are aligned with the updated value.
- Arithmetic is modulo 2^WIDTH; top=0 in up mode gives an event on every step with value staying 0.
- Load (priority over step):
  - value<=load_value, pcount<=0, done<=0; tick=0 and event=0 that cycle.
  - Load works regardless of enable or done.
- event_sticky:
  - Set on any edge where event is set. Else cleared when clear_event=1.
  - Simultaneous set and clear: set wins.
- Direction or one_shot changes take effect on the next step. No other state is disturbed.
- rst asserted mid-count returns all state to reset values on that edge, overriding load and step.

Test Plan:
1. Up periodic: rst, top=3, prescale=0, enable=1 -> value 1,2,3,0,1...; event high in the cycle value returns to 0 (every 4 cycles); tick high every cycle.
2. Prescale: top=2, prescale=2 -> value advances once per 3 enabled cycles; tick pulses 1 of 3; deassert enable mid-count -> value and pcount hold, resume exactly where stopped.
3. Down one-shot: load_value=5 with load, direction=0, one_shot=1 -> value 4..0, event once on the step at 0, done=1, value stays 0; load again -> done=0 and counting resumes.
4. Sticky and priority: generate event with clear_event held high that cycle -> event_sticky=1; next cycle clear_event=1 -> event_sticky=0. Load on a step cycle -> value=load_value, tick=0, event=0.
5. Boundary: WIDTH=4, top=15 up periodic -> wraps 15->0 with event. Lower top to 2 while value=9 -> next step is terminal, value->0, event.
6. Reset mid-operation: rst during a running count with event_sticky=1 and done=1 -> all outputs 0 on the next edge.
